// File: rtl/sample_pair_writer.sv
// Alternating even/odd FIFO writer for the FFT load path; kept samples are decimated by DECIM.
// Optional build macro DROP_COUNT_EN enables the saturating drop counter (tied to 0 otherwise).
module sample_pair_writer #(
  parameter int DATA_W  = 16,
  parameter int DECIM   = 4,
  parameter int DECIM_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              write_even,
  input  logic              write_odd,
  input  logic              full_even,
  input  logic              full_odd,
  output logic              even_wr,
  output logic [DATA_W-1:0] even_data,
  output logic              odd_wr,
  output logic [DATA_W-1:0] odd_data,
  output logic              pair_done,
  output logic              misalign,
  output logic [15:0]       drop_count
);

  typedef enum logic [1:0] {IDLE, WAIT_EVEN, WAIT_ODD} state_t;

  state_t              state_q;
  logic [DECIM_W-1:0]  decim_q;
  logic [DECIM_W-1:0]  decim_d;
  logic                even_wr_q, odd_wr_q, pair_done_q, misalign_q;
  logic [DATA_W-1:0]   even_data_q, odd_data_q;
  logic                enable;
  logic                kept;

  assign enable  = write_even & write_odd;
  assign kept    = sample_valid & (decim_q == '0);
  assign decim_d = (decim_q == DECIM_W'(DECIM - 1)) ? '0 : decim_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      decim_q     <= '0;
      even_wr_q   <= 1'b0;
      odd_wr_q    <= 1'b0;
      even_data_q <= '0;
      odd_data_q  <= '0;
      pair_done_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      even_wr_q   <= 1'b0;
      odd_wr_q    <= 1'b0;
      pair_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A strobe arriving with the enable edge is deliberately ignored.
          decim_q <= '0;
          if (enable) state_q <= WAIT_EVEN;
        end
        WAIT_EVEN: begin
          if (!enable) begin
            state_q <= IDLE;
            decim_q <= '0;
          end else begin
            if (sample_valid) decim_q <= decim_d;
            if (kept && !full_even) begin
              even_wr_q   <= 1'b1;
              even_data_q <= sample_in;
              state_q     <= WAIT_ODD;
            end
          end
        end
        WAIT_ODD: begin
          if (!enable) begin
            // The even half already sits in the FIFO without its partner.
            state_q    <= IDLE;
            decim_q    <= '0;
            misalign_q <= 1'b1;
          end else begin
            if (sample_valid) decim_q <= decim_d;
            if (kept && !full_odd) begin
              odd_wr_q    <= 1'b1;
              odd_data_q  <= sample_in;
              pair_done_q <= 1'b1;
              state_q     <= WAIT_EVEN;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          decim_q <= '0;
        end
      endcase
    end
  end

`ifdef DROP_COUNT_EN
  logic        drop_hit;
  logic [15:0] drop_q;

  assign drop_hit = enable & kept &
                    (((state_q == WAIT_EVEN) & full_even) | ((state_q == WAIT_ODD) & full_odd));

  always_ff @(posedge clk) begin
    if (reset)                               drop_q <= '0;
    else if (drop_hit && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

  assign even_wr   = even_wr_q;
  assign even_data = even_data_q;
  assign odd_wr    = odd_wr_q;
  assign odd_data  = odd_data_q;
  assign pair_done = pair_done_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_sample_pair_writer.sv
// Directed bench for sample_pair_writer: a DECIM=1 vector table plus hand sequences for reset and DECIM=4.
module tb_sample_pair_writer;

`ifdef DROP_COUNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample_in;
  logic        sample_valid, write_even, write_odd, full_even, full_odd;

  logic        ewr1, owr1, pd1, mis1;
  logic [15:0] ed1, od1, dc1;
  logic        ewr4, owr4, pd4, mis4;
  logic [15:0] ed4, od4, dc4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sample_pair_writer #(.DATA_W(16), .DECIM(1), .DECIM_W(3)) dut1 (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .write_even(write_even), .write_odd(write_odd), .full_even(full_even), .full_odd(full_odd),
    .even_wr(ewr1), .even_data(ed1), .odd_wr(owr1), .odd_data(od1),
    .pair_done(pd1), .misalign(mis1), .drop_count(dc1));

  sample_pair_writer #(.DATA_W(16), .DECIM(4), .DECIM_W(3)) dut4 (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .write_even(write_even), .write_odd(write_odd), .full_even(full_even), .full_odd(full_odd),
    .even_wr(ewr4), .even_data(ed4), .odd_wr(owr4), .odd_data(od4),
    .pair_done(pd4), .misalign(mis4), .drop_count(dc4));

  typedef struct {
    logic        sv;
    logic [15:0] d;
    logic        we, wo, fe, fo;
    logic        x_ewr;
    logic [15:0] x_ed;
    logic        x_owr;
    logic [15:0] x_od;
    logic        x_pd, x_mis;
    logic [15:0] x_drop;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [15:0] d, input logic we, input logic wo,
                       input logic fe, input logic fo);
    sample_valid = sv; sample_in = d; write_even = we; write_odd = wo;
    full_even = fe; full_odd = fo;
  endtask

  function automatic vec_t mk(input logic sv, input logic [15:0] d, input logic we, input logic wo,
                              input logic fe, input logic fo, input logic ewr, input logic [15:0] ed,
                              input logic owr, input logic [15:0] od, input logic pd,
                              input logic mis, input logic [15:0] drop);
    vec_t v;
    v.sv = sv; v.d = d; v.we = we; v.wo = wo; v.fe = fe; v.fo = fo;
    v.x_ewr = ewr; v.x_ed = ed; v.x_owr = owr; v.x_od = od; v.x_pd = pd; v.x_mis = mis;
    v.x_drop = DC_EN ? drop : 16'd0;
    return v;
  endfunction

  // Even/odd push strobes must never coincide.
  always @(negedge clk) begin
    if (reset === 1'b0 && ewr1 && owr1) begin
      bad++;
      $display("FAIL both_wr: even_wr=%b odd_wr=%b", ewr1, owr1);
    end
  end

  initial begin
    int ev_idx, od_idx, pd_cnt;
    logic [15:0] ev_val, od_val;

    //                sv  d        we wo fe fo  ewr ed       owr od       pd mis drop
    vecs[0]  = mk(1, 16'hAAAA, 1, 1, 0, 0,  0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    vecs[1]  = mk(1, 16'hBBBB, 1, 1, 0, 0,  1, 16'hBBBB, 0, 16'h0000, 0, 0, 0);
    vecs[2]  = mk(1, 16'hCCCC, 1, 1, 0, 0,  0, 16'hBBBB, 1, 16'hCCCC, 1, 0, 0);
    vecs[3]  = mk(1, 16'h0001, 1, 1, 0, 0,  1, 16'h0001, 0, 16'hCCCC, 0, 0, 0);
    vecs[4]  = mk(1, 16'h0002, 1, 1, 0, 0,  0, 16'h0001, 1, 16'h0002, 1, 0, 0);
    vecs[5]  = mk(1, 16'h0003, 1, 1, 0, 0,  1, 16'h0003, 0, 16'h0002, 0, 0, 0);
    vecs[6]  = mk(1, 16'h0004, 1, 1, 0, 0,  0, 16'h0003, 1, 16'h0004, 1, 0, 0);
    vecs[7]  = mk(0, 16'h0000, 1, 1, 0, 0,  0, 16'h0003, 0, 16'h0004, 0, 0, 0);
    vecs[8]  = mk(1, 16'h0005, 1, 1, 1, 0,  0, 16'h0003, 0, 16'h0004, 0, 0, 1);
    vecs[9]  = mk(1, 16'h0006, 1, 1, 1, 0,  0, 16'h0003, 0, 16'h0004, 0, 0, 2);
    vecs[10] = mk(1, 16'h0007, 1, 1, 1, 0,  0, 16'h0003, 0, 16'h0004, 0, 0, 3);
    vecs[11] = mk(1, 16'h0008, 1, 1, 0, 0,  1, 16'h0008, 0, 16'h0004, 0, 0, 3);
    vecs[12] = mk(1, 16'h0009, 1, 0, 0, 0,  0, 16'h0008, 0, 16'h0004, 0, 1, 3);
    vecs[13] = mk(1, 16'h000A, 1, 1, 0, 0,  0, 16'h0008, 0, 16'h0004, 0, 1, 3);
    vecs[14] = mk(1, 16'h000B, 1, 1, 0, 0,  1, 16'h000B, 0, 16'h0004, 0, 1, 3);
    vecs[15] = mk(1, 16'h000C, 1, 1, 0, 1,  0, 16'h000B, 0, 16'h0004, 0, 1, 4);
    vecs[16] = mk(1, 16'h000D, 1, 1, 0, 0,  0, 16'h000B, 1, 16'h000D, 1, 1, 4);
    vecs[17] = mk(1, 16'h000E, 0, 1, 0, 0,  0, 16'h000B, 0, 16'h000D, 0, 1, 4);

    reset = 1'b1;
    drive(0, 16'h0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_even_wr", 16'(ewr1), 16'd0);
    check("rst_even_data", ed1, 16'd0);
    check("rst_odd_wr", 16'(owr1), 16'd0);
    check("rst_odd_data", od1, 16'd0);
    check("rst_pair_done", 16'(pd1), 16'd0);
    check("rst_misalign", 16'(mis1), 16'd0);
    check("rst_drop", dc1, 16'd0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].sv, vecs[i].d, vecs[i].we, vecs[i].wo, vecs[i].fe, vecs[i].fo);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_even_wr", i), 16'(ewr1), 16'(vecs[i].x_ewr));
      check($sformatf("v%0d_even_data", i), ed1, vecs[i].x_ed);
      check($sformatf("v%0d_odd_wr", i), 16'(owr1), 16'(vecs[i].x_owr));
      check($sformatf("v%0d_odd_data", i), od1, vecs[i].x_od);
      check($sformatf("v%0d_pair_done", i), 16'(pd1), 16'(vecs[i].x_pd));
      check($sformatf("v%0d_misalign", i), 16'(mis1), 16'(vecs[i].x_mis));
      check($sformatf("v%0d_drop", i), dc1, vecs[i].x_drop);
      $display("vec %0d: sv=%b d=%h en=%b%b -> ewr=%b ed=%h owr=%b od=%h pd=%b mis=%b drop=%0d",
               i, vecs[i].sv, vecs[i].d, vecs[i].we, vecs[i].wo, ewr1, ed1, owr1, od1, pd1, mis1, dc1);
    end

    // Reset in the middle of a pair, then re-enable.
    drive(0, 16'h0, 1, 1, 0, 0);      @(posedge clk); #1;
    drive(1, 16'h1111, 1, 1, 0, 0);   @(posedge clk); #1;
    check("mid_even_wr", 16'(ewr1), 16'd1);
    check("mid_even_data", ed1, 16'h1111);
    reset = 1'b1;
    drive(1, 16'h2222, 1, 1, 0, 0);   @(posedge clk); #1;
    check("rst2_even_wr", 16'(ewr1), 16'd0);
    check("rst2_even_data", ed1, 16'd0);
    check("rst2_odd_wr", 16'(owr1), 16'd0);
    check("rst2_odd_data", od1, 16'd0);
    check("rst2_pair_done", 16'(pd1), 16'd0);
    check("rst2_misalign", 16'(mis1), 16'd0);
    check("rst2_drop", dc1, 16'd0);
    $display("reset mid-pair: ewr=%b ed=%h owr=%b od=%h mis=%b", ewr1, ed1, owr1, od1, mis1);
    reset = 1'b0;
    drive(0, 16'h0, 1, 1, 0, 0);      @(posedge clk); #1;
    drive(1, 16'h3333, 1, 1, 0, 0);   @(posedge clk); #1;
    check("rearm_even_wr", 16'(ewr1), 16'd1);
    check("rearm_even_data", ed1, 16'h3333);
    check("rearm_odd_wr", 16'(owr1), 16'd0);
    $display("re-enable: ewr=%b ed=%h owr=%b", ewr1, ed1, owr1);

    // DECIM=4: strobes 0x10..0x17 keep only 0x10 (even) and 0x14 (odd).
    reset = 1'b1;
    drive(0, 16'h0, 0, 0, 0, 0);      @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 16'h0, 1, 1, 0, 0);      @(posedge clk); #1;
    ev_idx = -1; od_idx = -1; pd_cnt = 0; ev_val = '0; od_val = '0;
    for (int i = 0; i < 10; i++) begin
      drive(i < 8, 16'(16'h10 + i), 1, 1, 0, 0);
      @(posedge clk); #1;
      if (ewr4) begin
        if (ev_idx == -1) begin ev_idx = i; ev_val = ed4; end
        else ev_idx = 100;
      end
      if (owr4) begin
        if (od_idx == -1) begin od_idx = i; od_val = od4; end
        else od_idx = 100;
      end
      if (pd4) pd_cnt++;
    end
    check("d4_even_cycle", 16'(ev_idx), 16'd0);
    check("d4_even_data", ev_val, 16'h0010);
    check("d4_odd_cycle", 16'(od_idx), 16'd4);
    check("d4_odd_data", od_val, 16'h0014);
    check("d4_pair_done_cnt", 16'(pd_cnt), 16'd1);
    $display("decim4: even@%0d=%h odd@%0d=%h pair_done=%0d", ev_idx, ev_val, od_idx, od_val, pd_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
